proc_eng_multi: RTL and testbench

Parametrised multi-lane processing engine: a signed dot-product MAC with LANES parallel lanes. Each lane has a private weight buffer; one data buffer is shared by all lanes. It computes LANES dot products of runtime length from one start pulse, then rounds, shifts and saturates each result. It sits in the CNN accelerator PE array; the controller loads buffers through the write port, pulses start and collects the per-lane results on done.

---
 rtl/proc_eng_multi.sv | 191 +++++++++++++++++++
 tb/tb_proc_eng_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_eng_multi.sv
// LANES-wide signed dot-product engine: per-lane weight buffers, one shared data buffer, round/shift/saturate.
// Latency N+3 cycles start->done; writes and starts are only honoured in IDLE, so no backpressure path exists.
module proc_eng_multi #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int LANES  = 4,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [LANE_W-1:0]       wr_lane,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       last_addr,
    input  logic [5:0]              shift,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*DATA_W-1:0] result,
    output logic [LANES-1:0]        sat_flag
);
    localparam int ACC_W  = 2*DATA_W + ADDR_W;
    localparam int PROD_W = 2*DATA_W;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic signed [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W-1:0]        last_q, last_d;
    logic [5:0]               shift_q, shift_d;
    logic                     drain_q, drain_d;
    logic                     rd_vld_q, rd_vld_d;
    logic                     prod_vld_q, prod_vld_d;
    logic                     done_q, done_d;
    logic signed [DATA_W-1:0] rd_w_q [LANES];
    logic signed [DATA_W-1:0] rd_w_d [LANES];
    logic signed [DATA_W-1:0] rd_d_q, rd_d_d;
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic signed [ACC_W-1:0]  acc_d [LANES];
    logic [LANES*DATA_W-1:0]  result_q, result_d;
    logic [LANES-1:0]         sat_q, sat_d;

    logic [DATA_W-1:0] wbuf [LANES][DEPTH];
    logic [DATA_W-1:0] dbuf [DEPTH];

    logic idle, do_write, do_start;
    assign idle     = (state_q == S_IDLE);
    assign do_write = idle && wr_en;
    assign do_start = idle && start && !wr_en;

    // Buffers are plain storage with no reset; a lane index beyond LANES matches nothing.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (wr_sel) begin
                dbuf[wr_addr] <= wr_data;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (int'(wr_lane) == i) wbuf[i][wr_addr] <= wr_data;
                end
            end
        end
    end

    logic signed [ACC_W:0]   bias;
    logic signed [ACC_W:0]   rnd_sum [LANES];
    logic signed [ACC_W:0]   rnd_shr [LANES];
    logic [LANES*DATA_W-1:0] out_dat;
    logic [LANES-1:0]        out_sat;

    // One guard bit above ACC_W keeps acc+bias from wrapping before the shift.
    always_comb begin
        bias    = (shift_q == 6'd0) ? '0 : (ONE << (shift_q - 6'd1));
        out_dat = '0;
        out_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            rnd_sum[i] = {acc_q[i][ACC_W-1], acc_q[i]} + bias;
            rnd_shr[i] = rnd_sum[i] >>> shift_q;
            if (int'(shift_q) >= ACC_W) rnd_shr[i] = {(ACC_W+1){acc_q[i][ACC_W-1]}};
            if (rnd_shr[i] > MAXV) begin
                out_dat[i*DATA_W +: DATA_W] = MAXV[DATA_W-1:0];
                out_sat[i]                  = 1'b1;
            end else if (rnd_shr[i] < MINV) begin
                out_dat[i*DATA_W +: DATA_W] = MINV[DATA_W-1:0];
                out_sat[i]                  = 1'b1;
            end else begin
                out_dat[i*DATA_W +: DATA_W] = rnd_shr[i][DATA_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        shift_d    = shift_q;
        drain_d    = drain_q;
        rd_vld_d   = (state_q == S_RUN);
        prod_vld_d = rd_vld_q;
        done_d     = 1'b0;
        result_d   = result_q;
        sat_d      = sat_q;
        rd_d_d     = dbuf[addr_q];
        for (int i = 0; i < LANES; i++) begin
            rd_w_d[i] = wbuf[i][addr_q];
            prod_d[i] = PROD_W'(rd_w_q[i]) * PROD_W'(rd_d_q);
            acc_d[i]  = prod_vld_q ? acc_q[i] + ACC_W'(prod_q[i]) : acc_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (do_start) begin
                    last_d  = last_addr;
                    shift_d = shift;
                    addr_d  = '0;
                    state_d = S_RUN;
                    for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                end
            end
            S_RUN: begin
                if (addr_q == last_q) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_OUT;
                else         drain_d = 1'b1;
            end
            S_OUT: begin
                result_d = out_dat;
                sat_d    = out_sat;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            drain_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
            done_q     <= 1'b0;
            rd_d_q     <= '0;
            result_q   <= '0;
            sat_q      <= '0;
            for (int i = 0; i < LANES; i++) begin
                rd_w_q[i] <= '0;
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            drain_q    <= drain_d;
            rd_vld_q   <= rd_vld_d;
            prod_vld_q <= prod_vld_d;
            done_q     <= done_d;
            rd_d_q     <= rd_d_d;
            result_q   <= result_d;
            sat_q      <= sat_d;
            for (int i = 0; i < LANES; i++) begin
                rd_w_q[i] <= rd_w_d[i];
                prod_q[i] <= prod_d[i];
                acc_q[i]  <= acc_d[i];
            end
        end
    end

    assign busy     = !idle;
    assign done     = done_q;
    assign result   = result_q;
    assign sat_flag = sat_q;
endmodule

// File: tb/tb_proc_eng_multi.sv
// Directed + randomized bench for proc_eng_multi against an arithmetic dot-product model.
module tb_proc_eng_multi;
    localparam int ACC_W = 2*16 + 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_sel, start;
    logic [1:0]  wr_lane;
    logic [5:0]  wr_addr, last_addr, shift;
    logic [15:0] wr_data;
    logic        busy, done;
    logic [63:0] result;
    logic [3:0]  sat_flag;

    logic        s_wr_en, s_wr_sel, s_start;
    logic [1:0]  s_wr_lane;
    logic [5:0]  s_wr_addr, s_last_addr, s_shift;
    logic [15:0] s_wr_data;
    logic        s_busy, s_done;
    logic [47:0] s_result;
    logic [2:0]  s_sat;

    always #5 clk = ~clk;

    proc_eng_multi #(.DATA_W(16), .ADDR_W(6), .LANES(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .last_addr(last_addr),
        .shift(shift), .busy(busy), .done(done), .result(result), .sat_flag(sat_flag)
    );

    proc_eng_multi #(.DATA_W(16), .ADDR_W(6), .LANES(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_lane(s_wr_lane),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .start(s_start), .last_addr(s_last_addr),
        .shift(s_shift), .busy(s_busy), .done(s_done), .result(s_result), .sat_flag(s_sat)
    );

    int     checks = 0;
    int     errors = 0;
    int     wm [4][64];
    int     dm [64];
    longint exp_r [4];
    bit     exp_s [4];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_res(input int i);
        return longint'($signed(result[i*16 +: 16]));
    endfunction

    // Exact dot product, then round-half-up shift and clamp to 16-bit signed.
    function automatic void compute(input int n, input int sh);
        for (int i = 0; i < 4; i++) begin
            longint acc;
            longint r;
            acc = 0;
            for (int k = 0; k < n; k++) acc += longint'(wm[i][k]) * longint'(dm[k]);
            if (sh >= ACC_W)  r = (acc < 0) ? -1 : 0;
            else if (sh == 0) r = acc;
            else              r = (acc + (longint'(1) << (sh - 1))) >>> sh;
            exp_s[i] = 1'b0;
            if (r > 32767)  begin r = 32767;  exp_s[i] = 1'b1; end
            if (r < -32768) begin r = -32768; exp_s[i] = 1'b1; end
            exp_r[i] = r;
        end
    endfunction

    task automatic wr(input bit sel, input int lane, input int addr, input int data);
        wr_en = 1'b1; wr_sel = sel; wr_lane = 2'(lane); wr_addr = 6'(addr); wr_data = 16'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (sel)           dm[addr] = int'(shortint'(data));
        else if (lane < 4) wm[lane][addr] = int'(shortint'(data));
    endtask

    task automatic fill(input int wbase, input int wmul, input int dval);
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < 4; i++) wr(1'b0, i, k, wbase + wmul*i);
            wr(1'b1, 0, k, dval);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so a chained call runs back-to-back.
    task automatic do_run(input int n, input int sh, input bit inject, input string tag);
        int lat;
        int bc;
        compute(n, sh);
        start = 1'b1; last_addr = 6'(n - 1); shift = 6'(sh);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        bc  = 0;
        for (int j = 0; j < 200; j++) begin
            if (inject && j == 0) begin
                wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd0; wr_data = 16'd100;
            end
            if (inject && j == 1) wr_en = 1'b0;
            if (done) begin lat = j; break; end
            if (busy) bc++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, n + 3);
        chk({tag, "_busy_cycles"}, bc, n + 3);
        chk({tag, "_busy_at_done"}, busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_res%0d", tag, i), lane_res(i), exp_r[i]);
            chk($sformatf("%s_sat%0d", tag, i), sat_flag[i], exp_s[i]);
        end
    endtask

    task automatic swr(input bit sel, input int lane, input int data);
        s_wr_en = 1'b1; s_wr_sel = sel; s_wr_lane = 2'(lane); s_wr_addr = 6'd0; s_wr_data = 16'(data);
        @(negedge clk);
        s_wr_en = 1'b0;
    endtask

    logic [63:0] saved;
    int          rn, rs, dn, slat;

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; last_addr = '0; shift = '0;
        s_wr_en = 1'b0; s_wr_sel = 1'b0; s_wr_lane = '0; s_wr_addr = '0; s_wr_data = '0;
        s_start = 1'b0; s_last_addr = '0; s_shift = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_sat", sat_flag, 0);
        rst = 1'b1;
        @(negedge clk);

        fill(1, 1, 2);
        do_run(4, 0, 1'b0, "basic");
        for (int i = 0; i < 4; i++) chk($sformatf("basic_const%0d", i), lane_res(i), 8*(i+1));
        @(negedge clk);

        wr(1'b0, 0, 0, -3); wr(1'b1, 0, 0, 5);
        do_run(1, 0, 1'b0, "len1_neg");
        chk("len1_neg_const", lane_res(0), -15);
        wr(1'b0, 0, 0, 3); wr(1'b1, 0, 0, 2);
        do_run(1, 2, 1'b0, "round_pos");
        chk("round_pos_const", lane_res(0), 2);
        wr(1'b0, 0, 0, -3);
        do_run(1, 2, 1'b0, "round_neg");
        chk("round_neg_const", lane_res(0), -1);
        @(negedge clk);

        fill(32767, 0, 32767);
        do_run(64, 0, 1'b0, "sat_pos");
        chk("sat_pos_const", lane_res(0), 32767);
        fill(-32768, 0, 32767);
        do_run(64, 0, 1'b0, "sat_neg");
        chk("sat_neg_const", lane_res(0), -32768);
        fill(1, 0, 1);
        do_run(4, 40, 1'b0, "big_shift");
        chk("big_shift_const", lane_res(0), 0);
        @(negedge clk);

        do_run(4, 0, 1'b1, "blocked_wr");
        saved = result;
        @(negedge clk);
        do_run(4, 0, 1'b0, "rerun");
        chk("rerun_same", longint'(result), longint'(saved));
        @(negedge clk);

        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd0; wr_data = 16'd7; start = 1'b1; last_addr = 6'd0;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0; dm[0] = 7;
        chk("wr_start_busy", busy, 0);
        @(negedge clk);
        chk("wr_start_busy_later", busy, 0);
        do_run(1, 0, 1'b0, "wr_start");
        @(negedge clk);

        do_run(4, 0, 1'b0, "b2b_a");
        do_run(2, 0, 1'b0, "b2b_b");
        @(negedge clk);

        for (int it = 0; it < 6; it++) begin
            rn = int'($urandom_range(1, 12));
            rs = int'($urandom_range(0, 24));
            for (int k = 0; k < rn; k++) begin
                for (int i = 0; i < 4; i++) wr(1'b0, i, k, int'($urandom));
                wr(1'b1, 0, k, int'($urandom));
            end
            do_run(rn, rs, 1'b0, $sformatf("rand%0d", it));
            @(negedge clk);
        end

        fill(1, 1, 2);
        start = 1'b1; last_addr = 6'd3; shift = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", longint'(result), 0);
        chk("midrst_sat", sat_flag, 0);
        rst = 1'b1;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst_no_done", dn, 0);
        do_run(4, 0, 1'b0, "post_rst");
        for (int i = 0; i < 4; i++) chk($sformatf("post_rst_const%0d", i), lane_res(i), 8*(i+1));
        @(negedge clk);

        for (int i = 0; i < 3; i++) swr(1'b0, i, 1);
        swr(1'b1, 0, 1);
        swr(1'b0, 3, 50);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        slat = -1;
        for (int j = 0; j < 50; j++) begin
            if (s_done) begin slat = j; break; end
            @(negedge clk);
        end
        chk("lane_oob_latency", slat, 4);
        for (int i = 0; i < 3; i++)
            chk($sformatf("lane_oob_res%0d", i), longint'($signed(s_result[i*16 +: 16])), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
